// File: rtl/mskstate_stream_conv.sv
// Streaming converter between share-major W-bit words and the bit-interleaved
// masked state. LOAD packs words into state_out; UNLOAD emits state_in as words.
module mskstate_stream_conv #(
  parameter int unsigned Nbits      = 128,
  parameter int unsigned d          = 2,
  parameter int unsigned W          = 32,
  parameter bit          SHARE0_MSB = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 start,
  input  logic                 mode_load,
  output logic                 busy,
  input  logic [W-1:0]         din_data,
  input  logic                 din_valid,
  output logic                 din_ready,
  output logic [d*Nbits-1:0]   state_out,
  output logic                 state_valid,
  input  logic                 state_ready,
  input  logic [d*Nbits-1:0]   state_in,
  output logic [W-1:0]         dout_data,
  output logic                 dout_valid,
  input  logic                 dout_ready
);

  localparam int unsigned NW    = Nbits / W;
  localparam int unsigned SBITS = d * Nbits;
  localparam int unsigned WCW   = (NW > 1) ? $clog2(NW) : 1;
  localparam int unsigned SCW   = (d > 1) ? $clog2(d) : 1;
  localparam int unsigned IW    = (SBITS > 1) ? $clog2(SBITS) : 1;
  localparam logic [WCW-1:0] WLAST = WCW'(NW - 1);
  localparam logic [SCW-1:0] SLAST = SCW'(d - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_LDONE,
    S_UNLOAD
  } state_e;

  state_e           state_q, state_d;
  logic [SBITS-1:0] sbuf_q, sbuf_d;
  logic [WCW-1:0]   wcnt_q, wcnt_d;
  logic [SCW-1:0]   scnt_q, scnt_d;
  logic [SBITS-1:0] deint;
  logic [IW-1:0]    word_base;
  logic             din_hs, dout_hs, last_word;

  function automatic int unsigned slot(input int unsigned i);
    return SHARE0_MSB ? (d - 1 - i) : i;
  endfunction

  // Share-major buffer position of the current word (scnt, wcnt).
  assign word_base = IW'((32'(scnt_q) * NW + 32'(wcnt_q)) * W);
  assign last_word = (scnt_q == SLAST) && (wcnt_q == WLAST);
  assign din_hs    = din_valid && din_ready && !clear;
  assign dout_hs   = dout_valid && dout_ready && !clear;
  assign dout_data = sbuf_q[word_base +: W];

  always_comb begin
    deint = '0;
    for (int unsigned i = 0; i < d; i++) begin
      for (int unsigned b = 0; b < Nbits; b++) begin
        deint[i*Nbits + b] = state_in[b*d + slot(i)];
      end
    end
  end

  always_comb begin
    state_out = '0;
    for (int unsigned i = 0; i < d; i++) begin
      for (int unsigned b = 0; b < Nbits; b++) begin
        state_out[b*d + slot(i)] = sbuf_q[i*Nbits + b];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   if (start) state_d = mode_load ? S_LOAD : S_UNLOAD;
        S_LOAD:   if (din_hs && last_word) state_d = S_LDONE;
        S_LDONE:  if (state_ready) state_d = S_IDLE;
        S_UNLOAD: if (dout_hs && last_word) state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy        = (state_q != S_IDLE);
    din_ready   = (state_q == S_LOAD);
    state_valid = (state_q == S_LDONE);
    dout_valid  = (state_q == S_UNLOAD);
  end

  // clear zeroes the counters but keeps the buffer contents.
  always_comb begin
    sbuf_d = sbuf_q;
    wcnt_d = wcnt_q;
    scnt_d = scnt_q;
    if (clear) begin
      wcnt_d = '0;
      scnt_d = '0;
    end else if (state_q == S_IDLE) begin
      wcnt_d = '0;
      scnt_d = '0;
      if (start && !mode_load) sbuf_d = deint;
    end else if (din_hs || dout_hs) begin
      if (din_hs) sbuf_d[word_base +: W] = din_data;
      if (last_word) begin
        wcnt_d = '0;
        scnt_d = '0;
      end else if (wcnt_q == WLAST) begin
        wcnt_d = '0;
        scnt_d = scnt_q + SCW'(1);
      end else begin
        wcnt_d = wcnt_q + WCW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sbuf_q <= '0;
      wcnt_q <= '0;
      scnt_q <= '0;
    end else begin
      sbuf_q <= sbuf_d;
      wcnt_q <= wcnt_d;
      scnt_q <= scnt_d;
    end
  end

endmodule

// File: tb/tb_mskstate_stream_conv.sv
// Scoreboard bench for mskstate_stream_conv: two instances (share 0 in MSB slot
// and in LSB slot) see the same stimulus and are checked against a bit-map model.
`timescale 1ns/1ps
module tb_mskstate_stream_conv;
  localparam int NB = 128, D = 2, W = 32, NW = NB / W, NWORDS = D * NW, SW = D * NB;

  logic clk = 1'b0, rst_n = 1'b1, clear = 1'b0, start = 1'b0, mode_load = 1'b0;
  logic din_valid = 1'b0, state_ready = 1'b0, dout_ready = 1'b0;
  logic [W-1:0]  din_data = '0;
  logic [SW-1:0] state_in = '0;
  logic busy_a, din_ready_a, state_valid_a, dout_valid_a;
  logic busy_b, din_ready_b, state_valid_b, dout_valid_b;
  logic [SW-1:0] state_out_a, state_out_b;
  logic [W-1:0]  dout_data_a, dout_data_b;

  int checks = 0, fails = 0;
  logic [SW-1:0] exp_state_a[$], exp_state_b[$];
  logic [W-1:0]  exp_word_a[$], exp_word_b[$];
  logic [W-1:0]  wq[NWORDS];

  always #5 clk = ~clk;

  mskstate_stream_conv #(.Nbits(NB), .d(D), .W(W), .SHARE0_MSB(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .clear(clear), .start(start), .mode_load(mode_load),
    .busy(busy_a), .din_data(din_data), .din_valid(din_valid), .din_ready(din_ready_a),
    .state_out(state_out_a), .state_valid(state_valid_a), .state_ready(state_ready),
    .state_in(state_in), .dout_data(dout_data_a), .dout_valid(dout_valid_a),
    .dout_ready(dout_ready));

  mskstate_stream_conv #(.Nbits(NB), .d(D), .W(W), .SHARE0_MSB(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(clear), .start(start), .mode_load(mode_load),
    .busy(busy_b), .din_data(din_data), .din_valid(din_valid), .din_ready(din_ready_b),
    .state_out(state_out_b), .state_valid(state_valid_b), .state_ready(state_ready),
    .state_in(state_in), .dout_data(dout_data_b), .dout_valid(dout_valid_b),
    .dout_ready(dout_ready));

  function automatic void check(input string name, input logic [SW-1:0] act,
                                input logic [SW-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Bit b of share i lands at b*D + slot, slot = D-1-i (msb) or i.
  function automatic logic [SW-1:0] interleave(input logic [SW-1:0] sm, input bit msb);
    logic [SW-1:0] r;
    r = '0;
    for (int i = 0; i < D; i++)
      for (int b = 0; b < NB; b++)
        r[b*D + (msb ? D-1-i : i)] = sm[i*NB + b];
    return r;
  endfunction

  function automatic logic [SW-1:0] deinterleave(input logic [SW-1:0] st, input bit msb);
    logic [SW-1:0] r;
    r = '0;
    for (int i = 0; i < D; i++)
      for (int b = 0; b < NB; b++)
        r[i*NB + b] = st[b*D + (msb ? D-1-i : i)];
    return r;
  endfunction

  function automatic logic [SW-1:0] words_to_sm();
    logic [SW-1:0] sm;
    sm = '0;
    for (int k = 0; k < NWORDS; k++) sm[k*W +: W] = wq[k];
    return sm;
  endfunction

  // Monitor: pops expectations on every output handshake; checks stall stability.
  logic [SW-1:0] prev_state_a;
  logic [W-1:0]  prev_dout_a, prev_dout_b;
  bit st_stall = 1'b0, do_stall = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      st_stall = 1'b0;
      do_stall = 1'b0;
    end else begin
      if (st_stall && state_valid_a) check("state_hold", state_out_a, prev_state_a);
      if (do_stall && dout_valid_a) begin
        check("dout_hold_a", dout_data_a, prev_dout_a);
        check("dout_hold_b", dout_data_b, prev_dout_b);
      end
      if (state_valid_a && state_ready && !clear) begin
        check("state_valid_b", state_valid_b, 1);
        if (exp_state_a.size() == 0) check("state_unexpected", 1, 0);
        else begin
          check("state_out_a", state_out_a, exp_state_a.pop_front());
          check("state_out_b", state_out_b, exp_state_b.pop_front());
        end
      end
      if (dout_valid_a && dout_ready && !clear) begin
        check("dout_valid_b", dout_valid_b, 1);
        if (exp_word_a.size() == 0) check("dout_unexpected", 1, 0);
        else begin
          check("dout_a", dout_data_a, exp_word_a.pop_front());
          check("dout_b", dout_data_b, exp_word_b.pop_front());
        end
      end
      st_stall     = state_valid_a && !state_ready;
      prev_state_a = state_out_a;
      do_stall     = dout_valid_a && !dout_ready;
      prev_dout_a  = dout_data_a;
      prev_dout_b  = dout_data_b;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_txn(input bit load);
    start = 1'b1;
    mode_load = load;
    tick();
    start = 1'b0;
  endtask

  task automatic send_words(input int first, input int last);
    int k = first;
    int guard = 0;
    while (k <= last && guard < 1000) begin
      din_data  = wq[k];
      din_valid = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (din_valid && din_ready_a) k++;
      tick();
      guard++;
    end
    din_valid = 1'b0;
    check("send_timeout", k, last + 1);
  endtask

  task automatic full_load(input int hold, input bit chk_const,
                           input logic [SW-1:0] ca, input logic [SW-1:0] cb);
    logic [SW-1:0] sm;
    sm = words_to_sm();
    exp_state_a.push_back(interleave(sm, 1'b1));
    exp_state_b.push_back(interleave(sm, 1'b0));
    state_ready = 1'b0;
    start_txn(1'b1);
    send_words(0, NWORDS - 1);
    check("valid_latency", state_valid_a, 1);
    if (chk_const) begin
      check("const_a", state_out_a, ca);
      check("const_b", state_out_b, cb);
    end
    for (int h = 0; h < hold; h++) begin
      start = h[0];
      mode_load = $urandom_range(0, 1);
      @(negedge clk);
      check("bp_valid", state_valid_a, 1);
      check("bp_din_ready", din_ready_a, 0);
      check("bp_busy", busy_a, 1);
      tick();
      start = 1'b0;
    end
    state_ready = 1'b1;
    tick();
    state_ready = 1'b0;
    check("idle_after_ack", {busy_a, state_valid_a}, 0);
  endtask

  task automatic full_unload(input logic [SW-1:0] st, input int stall_pct);
    logic [SW-1:0] a, b;
    int n = 0;
    int guard = 0;
    a = deinterleave(st, 1'b1);
    b = deinterleave(st, 1'b0);
    for (int k = 0; k < NWORDS; k++) begin
      exp_word_a.push_back(a[k*W +: W]);
      exp_word_b.push_back(b[k*W +: W]);
    end
    state_in = st;
    start_txn(1'b0);
    state_in = {8{$urandom()}};
    check("first_word_valid", dout_valid_a, 1);
    while (n < NWORDS && guard < 1000) begin
      dout_ready = ($urandom_range(0, 99) >= stall_pct);
      @(negedge clk);
      if (dout_valid_a && dout_ready) n++;
      tick();
      guard++;
    end
    dout_ready = 1'b0;
    check("unload_timeout", n, NWORDS);
    check("idle_after_unload", {busy_a, dout_valid_a}, 0);
  endtask

  task automatic rand_words();
    for (int k = 0; k < NWORDS; k++) wq[k] = $urandom();
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_state_out"}, state_out_a, '0);
    check({name, "_ctl"}, {busy_a, din_ready_a, state_valid_a, dout_valid_a}, 0);
    check({name, "_dout"}, dout_data_a, 0);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #10 check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int k = 0; k < NWORDS; k++) wq[k] = (k < NW) ? 32'hFFFF_FFFF : 32'h0;
    full_load(0, 1'b1, {64{4'hA}}, {64{4'h5}});

    repeat (4) begin
      rand_words();
      full_load($urandom_range(0, 3), 1'b0, '0, '0);
    end

    rand_words();
    full_load(10, 1'b0, '0, '0);

    full_unload({64{4'hA}}, 50);

    repeat (3) begin
      rand_words();
      full_load($urandom_range(0, 2), 1'b0, '0, '0);
      full_unload(interleave(words_to_sm(), 1'b1), 30);
    end
    repeat (2) full_unload({8{$urandom()}}, 40);

    rand_words();
    start_txn(1'b1);
    send_words(0, 2);
    rst_n = 1'b0;
    #1 check_all_zero("midload_reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    rand_words();
    full_load(1, 1'b0, '0, '0);

    rand_words();
    start_txn(1'b1);
    send_words(0, 3);
    din_data = wq[4];
    din_valid = 1'b1;
    clear = 1'b1;
    @(negedge clk);
    check("clear_din_ready", din_ready_a, 1);
    tick();
    clear = 1'b0;
    din_valid = 1'b0;
    check("clear_idle", busy_a, 0);
    repeat (5) begin
      @(negedge clk);
      check("clear_no_valid", state_valid_a, 0);
    end
    tick();
    start = 1'b1;
    clear = 1'b1;
    mode_load = 1'b1;
    tick();
    start = 1'b0;
    clear = 1'b0;
    check("clear_start_idle", busy_a, 0);
    rand_words();
    full_load(0, 1'b0, '0, '0);

    repeat (3) tick();
    check("exp_state_empty", exp_state_a.size(), 0);
    check("exp_word_empty", exp_word_a.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
